data_mem_ctrl: RTL and testbench

- Parametrised data-side memory controller between the core load/store port, the shared block-RAM port B and the MMIO peripherals.
- Decodes RAM vs MMIO region and steers byte/halfword lanes on writes.
- Sign- or zero-extends reads and gives a ready handshake with fixed one-cycle read latency.
- Serves N UART channels and stalls TX writes to a full UART; flags misaligned or unmapped accesses.

---
 rtl/data_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: connects the core load/store port to block-RAM
// port B and to the MMIO page (display, LEDs, N UART channels).
// Stores complete in the request cycle. Loads take one extra cycle (IDLE -> RESP)
// so that block-RAM read data and captured MMIO values arrive together.
module data_mem_ctrl #(
    parameter logic [19:0] MMIO_BASE   = 20'hAAAAA,
    parameter int          RAM_AW      = 11,
    parameter int          N_UART      = 2,
    parameter logic [11:0] UART_STRIDE = 12'h010,
    parameter int          LED_W       = 16
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  mem_rea,
    input  logic                  mem_wea,
    input  logic [31:0]           mem_addr,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [31:0]           mem_din,
    output logic [31:0]           mem_dout,
    output logic                  mem_ready,
    output logic                  mem_err,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    output logic                  disp_wea,
    output logic [31:0]           disp_dat,
    output logic [LED_W-1:0]      led,
    output logic [N_UART-1:0]     tx_wen,
    output logic [8*N_UART-1:0]   uart_din,
    output logic [N_UART-1:0]     rx_ren,
    input  logic [8*N_UART-1:0]   uart_dout,
    input  logic [N_UART-1:0]     rx_data_present,
    input  logic [N_UART-1:0]     tx_full
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]       r_state;
    logic [31:0]      r_doutHold;
    logic             r_dispWea;
    logic [31:0]      r_dispDat;
    logic [LED_W-1:0] r_led;
    logic             r_capIsRam;
    logic [31:0]      r_cap;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic             r_uns;

    logic [19:0]       w_upper;
    logic [11:0]       w_off;
    logic              w_isRam;
    logic              w_isMmio;
    logic              w_unmapped;
    logic              w_misaligned;
    logic              w_idle;
    logic              w_err;
    logic              w_wrOk;
    logic              w_rdAccept;
    logic              w_hitDispWea;
    logic              w_hitDispDat;
    logic              w_hitLed;
    logic              w_uartData;
    logic              w_uartStat;
    logic [N_UART-1:0] w_uartSel;
    logic              w_selTxFull;
    logic              w_selRxPresent;
    logic [7:0]        w_selRxByte;
    logic [11:0]       w_base;
    logic              w_txStall;
    logic [31:0]       w_mmioRead;
    logic [31:0]       w_src;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_readData;

    assign w_upper    = mem_addr[31:12];
    assign w_off      = mem_addr[11:0];
    assign w_isRam    = (w_upper < MMIO_BASE);
    assign w_isMmio   = (w_upper == MMIO_BASE);
    assign w_unmapped = !w_isRam && !w_isMmio;

    // Size 3 is treated as a word, so any size with bit 1 set needs word alignment.
    assign w_misaligned = ((mem_size == 2'd1) && mem_addr[0]) ||
                          (mem_size[1] && (mem_addr[1:0] != 2'b00));

    // A simultaneous load and store request is handled as a store.
    assign w_idle     = !Rst && (r_state == ST_IDLE);
    assign w_err      = w_idle && (mem_rea || mem_wea) && (w_misaligned || w_unmapped);
    assign w_wrOk     = w_idle && mem_wea && !w_misaligned && !w_unmapped;
    assign w_rdAccept = w_idle && mem_rea && !mem_wea && !w_misaligned && !w_unmapped;

    assign w_hitDispWea = w_isMmio && ({w_off[11:2], 2'b00} == 12'h004);
    assign w_hitDispDat = w_isMmio && ({w_off[11:2], 2'b00} == 12'h008);
    assign w_hitLed     = w_isMmio && ({w_off[11:2], 2'b00} == 12'h00C);

    // Locate the UART channel addressed by the offset; lowest channel wins on overlap.
    always_comb begin
        w_uartData     = 1'b0;
        w_uartStat     = 1'b0;
        w_uartSel      = '0;
        w_selTxFull    = 1'b0;
        w_selRxPresent = 1'b0;
        w_selRxByte    = 8'h00;
        w_base         = 12'h400;
        for (int k = N_UART - 1; k >= 0; k--) begin
            w_base = 12'h400 + 12'(k) * UART_STRIDE;
            if (w_isMmio && ({w_off[11:2], 2'b00} == w_base)) begin
                w_uartData     = 1'b1;
                w_uartStat     = 1'b0;
                w_uartSel      = '0;
                w_uartSel[k]   = 1'b1;
                w_selTxFull    = tx_full[k];
                w_selRxPresent = rx_data_present[k];
                w_selRxByte    = uart_dout[8*k +: 8];
            end else if (w_isMmio && ({w_off[11:2], 2'b00} == (w_base + 12'h004))) begin
                w_uartData     = 1'b0;
                w_uartStat     = 1'b1;
                w_uartSel      = '0;
                w_uartSel[k]   = 1'b1;
                w_selTxFull    = tx_full[k];
                w_selRxPresent = rx_data_present[k];
                w_selRxByte    = uart_dout[8*k +: 8];
            end
        end
    end

    assign w_txStall = w_wrOk && w_uartData && w_selTxFull;

    // RAM port: enabled on any accepted RAM access, byte lanes enabled on stores only.
    always_comb begin
        ram_en = (w_wrOk || w_rdAccept) && w_isRam;
        ram_we = 4'b0000;
        if (w_wrOk && w_isRam) begin
            case (mem_size)
                2'd0:    ram_we = 4'b0001 << mem_addr[1:0];
                2'd1:    ram_we = 4'b0011 << mem_addr[1:0];
                default: ram_we = 4'b1111;
            endcase
        end
    end

    assign ram_addr = mem_addr[RAM_AW+1:2];

    // Replicate narrow store data across the word so the enabled lanes see it.
    always_comb begin
        case (mem_size)
            2'd0:    ram_din = {4{mem_din[7:0]}};
            2'd1:    ram_din = {2{mem_din[15:0]}};
            default: ram_din = mem_din;
        endcase
    end

    // UART strobes: TX only when the FIFO has room, RX pop only when data is waiting.
    always_comb begin
        tx_wen   = '0;
        rx_ren   = '0;
        uart_din = '0;
        if (w_wrOk && w_uartData && !w_selTxFull) begin
            tx_wen = w_uartSel;
        end
        if (w_rdAccept && w_uartData && w_selRxPresent) begin
            rx_ren = w_uartSel;
        end
        for (int k = 0; k < N_UART; k++) begin
            if (tx_wen[k]) begin
                uart_din[8*k +: 8] = mem_din[7:0];
            end
        end
    end

    // Value an MMIO load returns; unknown offsets and an empty RX FIFO read as 0.
    always_comb begin
        w_mmioRead = 32'h0;
        if (w_hitDispWea) begin
            w_mmioRead = {31'h0, r_dispWea};
        end else if (w_hitDispDat) begin
            w_mmioRead = r_dispDat;
        end else if (w_hitLed) begin
            w_mmioRead = 32'(r_led);
        end else if (w_uartData && w_selRxPresent) begin
            w_mmioRead = {24'h0, w_selRxByte};
        end else if (w_uartStat) begin
            w_mmioRead = {30'h0, w_selTxFull, w_selRxPresent};
        end
    end

    // Lane extraction and sign/zero extension of the response word.
    always_comb begin
        w_src = r_capIsRam ? ram_dout : r_cap;
        case (r_lane)
            2'd0:    w_byte = w_src[7:0];
            2'd1:    w_byte = w_src[15:8];
            2'd2:    w_byte = w_src[23:16];
            default: w_byte = w_src[31:24];
        endcase
        w_half = r_lane[1] ? w_src[31:16] : w_src[15:0];
        case (r_size)
            2'd0:    w_readData = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_readData = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_readData = w_src;
        endcase
    end

    // Handshake outputs: loads wait for RESP, stalled UART stores wait for TX room.
    always_comb begin
        mem_ready = 1'b1;
        mem_err   = w_err;
        if (Rst) begin
            mem_ready = 1'b0;
        end else if (r_state == ST_RESP) begin
            mem_ready = 1'b1;
        end else if (w_rdAccept || w_txStall) begin
            mem_ready = 1'b0;
        end
    end

    // Load data is live during RESP, zero on an error cycle, and held otherwise.
    always_comb begin
        if (Rst) begin
            mem_dout = 32'h0;
        end else if (r_state == ST_RESP) begin
            mem_dout = w_readData;
        end else if (w_err) begin
            mem_dout = 32'h0;
        end else begin
            mem_dout = r_doutHold;
        end
    end

    // Load FSM and capture of the request attributes needed in RESP.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_doutHold <= 32'h0;
            r_capIsRam <= 1'b0;
            r_cap      <= 32'h0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_doutHold <= w_readData;
            r_state    <= ST_IDLE;
        end else if (w_err) begin
            r_doutHold <= 32'h0;
        end else if (w_rdAccept) begin
            r_state    <= ST_RESP;
            r_capIsRam <= w_isRam;
            r_cap      <= w_mmioRead;
            r_lane     <= mem_addr[1:0];
            r_size     <= mem_size;
            r_uns      <= mem_unsigned;
        end
    end

    // MMIO register stores take effect on the edge that completes the request.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_dispWea <= 1'b0;
            r_dispDat <= 32'h0;
            r_led     <= '0;
        end else if (w_wrOk) begin
            if (w_hitDispWea) r_dispWea <= mem_din[0];
            if (w_hitDispDat) r_dispDat <= mem_din;
            if (w_hitLed)     r_led     <= mem_din[LED_W-1:0];
        end
    end

    assign disp_wea = r_dispWea;
    assign disp_dat = r_dispDat;
    assign led      = r_led;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: RAM lane steering and extension, error
// handling, UART data/status/stall behaviour, LED register and reset abort.
module tb_data_mem_ctrl;

    logic        clk;
    logic        Rst;
    logic        mem_rea;
    logic        mem_wea;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ready;
    logic        mem_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        disp_wea;
    logic [31:0] disp_dat;
    logic [15:0] led;
    logic [1:0]  tx_wen;
    logic [15:0] uart_din;
    logic [1:0]  rx_ren;
    logic [15:0] uart_dout;
    logic [1:0]  rx_data_present;
    logic [1:0]  tx_full;

    int checkCount = 0;
    int passCount  = 0;

    data_mem_ctrl dut (
        .clk             (clk),
        .Rst             (Rst),
        .mem_rea         (mem_rea),
        .mem_wea         (mem_wea),
        .mem_addr        (mem_addr),
        .mem_size        (mem_size),
        .mem_unsigned    (mem_unsigned),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_ready       (mem_ready),
        .mem_err         (mem_err),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_din         (ram_din),
        .ram_dout        (ram_dout),
        .disp_wea        (disp_wea),
        .disp_dat        (disp_dat),
        .led             (led),
        .tx_wen          (tx_wen),
        .uart_din        (uart_din),
        .rx_ren          (rx_ren),
        .uart_dout       (uart_dout),
        .rx_data_present (rx_data_present),
        .tx_full         (tx_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one core request, then let combinational outputs settle.
    task automatic applyStimulus(input logic rea, input logic wea, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] din);
        mem_rea      = rea;
        mem_wea      = wea;
        mem_addr     = addr;
        mem_size     = size;
        mem_unsigned = uns;
        mem_din      = din;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    initial begin
        Rst             = 1'b1;
        mem_rea         = 1'b0;
        mem_wea         = 1'b0;
        mem_addr        = 32'h0;
        mem_size        = 2'd0;
        mem_unsigned    = 1'b0;
        mem_din         = 32'h0;
        ram_dout        = 32'h0;
        uart_dout       = 16'h0;
        rx_data_present = 2'b00;
        tx_full         = 2'b00;

        // Reset held for two edges
        tick();
        tick();
        checkOutput("rst_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("rst_err", {31'h0, mem_err}, 32'h0);
        checkOutput("rst_strobes", {22'h0, ram_en, ram_we, tx_wen, rx_ren, disp_wea}, 32'h0);
        checkOutput("rst_dout", mem_dout, 32'h0);
        checkOutput("rst_led", {16'h0, led}, 32'h0);
        checkOutput("rst_disp_dat", disp_dat, 32'h0);
        Rst = 1'b0;
        #1;
        checkOutput("idle_ready", {31'h0, mem_ready}, 32'h1);

        // Byte store 0xA5 to 0x102
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0102, 2'd0, 1'b0, 32'h0000_00A5);
        checkOutput("sb_ram_en", {31'h0, ram_en}, 32'h1);
        checkOutput("sb_ram_we", {28'h0, ram_we}, 32'h4);
        checkOutput("sb_ram_din", ram_din, 32'hA5A5_A5A5);
        checkOutput("sb_ready", {31'h0, mem_ready}, 32'h1);

        // Halfword store to 0x2 uses the upper two lanes
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0002, 2'd1, 1'b0, 32'h1234_BEEF);
        checkOutput("sh_ram_we", {28'h0, ram_we}, 32'hC);
        checkOutput("sh_ram_din", ram_din, 32'hBEEF_BEEF);

        // Signed byte load from 0x102
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0102, 2'd0, 1'b0, 32'h0);
        checkOutput("lb_accept_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("lb_ram_en", {31'h0, ram_en}, 32'h1);
        checkOutput("lb_ram_we", {28'h0, ram_we}, 32'h0);
        checkOutput("lb_ram_addr", {21'h0, ram_addr}, 32'h40);
        tick();
        ram_dout = 32'h00A5_0000;
        #1;
        checkOutput("lb_resp_ready", {31'h0, mem_ready}, 32'h1);
        checkOutput("lb_resp_dout", mem_dout, 32'hFFFF_FFA5);
        checkOutput("lb_resp_ram_en", {31'h0, ram_en}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        ram_dout = 32'h0;
        #1;
        checkOutput("lb_hold_dout", mem_dout, 32'hFFFF_FFA5);

        // Unsigned byte load from 0x102
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0102, 2'd0, 1'b1, 32'h0);
        tick();
        ram_dout = 32'h00A5_0000;
        #1;
        checkOutput("lbu_dout", mem_dout, 32'h0000_00A5);

        // Signed halfword load from 0x6
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0006, 2'd1, 1'b0, 32'h0);
        tick();
        ram_dout = 32'h8001_1234;
        #1;
        checkOutput("lh_dout", mem_dout, 32'hFFFF_8001);

        // Misaligned word load from 0x6
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0006, 2'd2, 1'b0, 32'h0);
        checkOutput("lw_mis_err", {31'h0, mem_err}, 32'h1);
        checkOutput("lw_mis_ready", {31'h0, mem_ready}, 32'h1);
        checkOutput("lw_mis_ram_en", {31'h0, ram_en}, 32'h0);
        checkOutput("lw_mis_dout", mem_dout, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        checkOutput("lw_mis_err_pulse", {31'h0, mem_err}, 32'h0);
        checkOutput("lw_mis_dout_hold", mem_dout, 32'h0);

        // UART1 data read with a byte waiting
        rx_data_present = 2'b10;
        uart_dout       = 16'h4100;
        tick();
        applyStimulus(1'b1, 1'b0, 32'hAAAA_A410, 2'd2, 1'b0, 32'h0);
        checkOutput("u1_rx_ren", {30'h0, rx_ren}, 32'h2);
        checkOutput("u1_accept_ready", {31'h0, mem_ready}, 32'h0);
        tick();
        checkOutput("u1_rx_ren_once", {30'h0, rx_ren}, 32'h0);
        checkOutput("u1_dout", mem_dout, 32'h0000_0041);

        // UART1 status read with TX full and RX empty
        rx_data_present = 2'b00;
        tx_full         = 2'b10;
        tick();
        applyStimulus(1'b1, 1'b0, 32'hAAAA_A414, 2'd2, 1'b0, 32'h0);
        tick();
        checkOutput("u1_status", mem_dout, 32'h0000_0002);

        // Unknown MMIO offset reads as zero without error
        tx_full = 2'b00;
        tick();
        applyStimulus(1'b1, 1'b0, 32'hAAAA_A0F0, 2'd2, 1'b0, 32'h0);
        checkOutput("mmio_unk_err", {31'h0, mem_err}, 32'h0);
        tick();
        checkOutput("mmio_unk_dout", mem_dout, 32'h0);

        // UART0 store stalls while its TX FIFO is full
        tx_full = 2'b01;
        tick();
        applyStimulus(1'b0, 1'b1, 32'hAAAA_A400, 2'd2, 1'b0, 32'h0000_0055);
        for (int c = 0; c < 3; c++) begin
            checkOutput("u0_stall_ready", {31'h0, mem_ready}, 32'h0);
            checkOutput("u0_stall_tx_wen", {30'h0, tx_wen}, 32'h0);
            tick();
        end
        tx_full = 2'b00;
        #1;
        checkOutput("u0_tx_wen", {30'h0, tx_wen}, 32'h1);
        checkOutput("u0_uart_din", {16'h0, uart_din}, 32'h0055);
        checkOutput("u0_ready", {31'h0, mem_ready}, 32'h1);

        // LED store lands on the completing edge
        tick();
        applyStimulus(1'b0, 1'b1, 32'hAAAA_A00C, 2'd2, 1'b0, 32'h0000_1234);
        checkOutput("led_before", {16'h0, led}, 32'h0);
        tick();
        checkOutput("led_after", {16'h0, led}, 32'h1234);

        // Display data store
        applyStimulus(1'b0, 1'b1, 32'hAAAA_A008, 2'd2, 1'b0, 32'hDEAD_BEEF);
        tick();
        checkOutput("disp_dat", disp_dat, 32'hDEAD_BEEF);

        // Unmapped store leaves the LED register alone
        applyStimulus(1'b0, 1'b1, 32'hAAAA_B000, 2'd2, 1'b0, 32'h0000_FFFF);
        checkOutput("unmap_err", {31'h0, mem_err}, 32'h1);
        checkOutput("unmap_ready", {31'h0, mem_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        checkOutput("unmap_led", {16'h0, led}, 32'h1234);

        // Reset during RESP aborts the load
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'h0);
        tick();
        ram_dout = 32'h1357_9BDF;
        Rst      = 1'b1;
        #1;
        checkOutput("rst_resp_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("rst_resp_dout", mem_dout, 32'h0);
        tick();
        Rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        checkOutput("rst_after_ready", {31'h0, mem_ready}, 32'h1);
        checkOutput("rst_after_dout", mem_dout, 32'h0);
        checkOutput("rst_after_led", {16'h0, led}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
